// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer: FSM state encoding,
// LFSR/MISR feedback tap masks and default widths.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int DEF_IN_W  = 19;
    localparam int DEF_OUT_W = 20;
    localparam int DEF_CNT_W = 16;

    // Feedback taps: LFSR x18^x5^x1^x0, MISR x19^x16
    localparam logic [18:0] LFSR_TAPS = 19'h40023;
    localparam logic [19:0] MISR_TAPS = 20'h90000;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift with tap feedback, XOR in response.
// Synchronous clear has priority over enable.
module bist_misr
    import bist_pkg::*;
#(
    parameter int              OUT_W = DEF_OUT_W,
    parameter logic [OUT_W-1:0] TAPS = OUT_W'(MISR_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [OUT_W-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[OUT_W-2:0], ^(sig & TAPS)} ^ din;
        end
    end

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer: LFSR pattern source, settle timer, MISR compaction, golden compare.
// Optional `abort` input enabled by defining BIST_ABORT_EN.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef BIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic [CNT_W-1:0] pattern_count,
    input  logic [IN_W-1:0]  seed,
    input  logic [OUT_W-1:0] golden,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             state, state_n;
    logic [IN_W-1:0]    lfsr;
    logic [CNT_W-1:0]   cnt, cnt_inc, count_q;
    logic [SET_W-1:0]   settle_cnt;
    logic               settle_done;
    logic               load, cap;

    assign cnt_inc     = cnt + CNT_W'(1);
    assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        cap     = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_LOAD;
                    load    = 1'b1;
                end
            end
            S_LOAD:    state_n = (count_q == '0) ? S_DONE : S_APPLY;
            S_APPLY:   if (settle_done) state_n = S_CAPTURE;
            S_CAPTURE: begin
                cap     = 1'b1;
                state_n = (cnt_inc == count_q) ? S_DONE : S_APPLY;
            end
            default:   state_n = S_IDLE;
        endcase
`ifdef BIST_ABORT_EN
        // Abort only bites mid-run; lfsr/misr freeze where they are
        if (abort && busy) begin
            state_n = S_IDLE;
            cap     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == S_APPLY && !settle_done) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= IN_W'(1);
            cnt     <= '0;
            count_q <= '0;
        end else if (load) begin
            lfsr    <= (seed == '0) ? IN_W'(1) : seed;
            cnt     <= '0;
            count_q <= pattern_count;
        end else if (cap) begin
            lfsr    <= {lfsr[IN_W-2:0], ^(lfsr & IN_W'(LFSR_TAPS))};
            cnt     <= cnt_inc;
        end
    end

    bist_misr #(
        .OUT_W (OUT_W)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .en    (cap),
        .din   (dut_out),
        .sig   (signature)
    );

    assign dut_in = lfsr;
    assign busy   = (state == S_LOAD) || (state == S_APPLY) || (state == S_CAPTURE);
    assign done   = (state == S_DONE);
    assign pass   = done && (signature == golden);

endmodule
